// File: rtl/branch_pkg.sv
// branch_pkg: shared types and default sizes for the branch resolve unit.
package branch_pkg;
   localparam int DEPTH_DEF = 4;
   localparam int PC_W_DEF = 32;
   typedef enum logic {RUN, FLUSH} state_t;
   typedef struct packed {
      logic                pred_taken;
      logic [PC_W_DEF-1:0] fallthru;
   } entry_t;
endpackage

// File: rtl/branch_inflight_fifo.sv
// branch_inflight_fifo: circular buffer of in-flight branches with single-cycle flush.
module branch_inflight_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 33
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q;
   always_ff @(posedge clock)
      if (push) mem_q[wr_q] <= wdata;
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_q    <= rd_q;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   assign rdata = mem_q[rd_q];
   assign count = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves in-flight predicted branches, trains the predictor, redirects on mispredict.
// Optional saturating statistics counters under BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int PC_W = PC_W_DEF
`ifdef BRANCH_RESOLVE_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            pred_valid,
   input  logic            pred_taken,
   input  logic [PC_W-1:0] pred_fallthru,
   output logic            pred_ready,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [PC_W-1:0] res_target,
   output logic            upd_valid,
   output logic            upd_taken,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
   output logic            empty,
   output logic            underflow_err
`ifdef BRANCH_RESOLVE_STATS_EN
   , output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispred
`endif
);
   localparam int AW = $clog2(DEPTH);
   typedef struct packed {
      logic            pred_taken;
      logic [PC_W-1:0] fallthru;
   } ent_t;
   ent_t            head;
   logic [AW:0]     count;
   state_t          state_q, state_d;
   logic            upd_valid_q, upd_taken_q, mispredict_q, underflow_q;
   logic [PC_W-1:0] redirect_q, redirect_d;
   logic            push, pop, mis;
   assign empty      = (count == '0);
   assign pred_ready = (state_q == RUN) && (count < (AW+1)'(DEPTH));
   assign push       = pred_valid && pred_ready;
   assign pop        = res_valid && !empty;
   assign mis        = pop && (res_taken != head.pred_taken);
   branch_inflight_fifo #(.DEPTH(DEPTH), .W(PC_W+1)) u_fifo (
      .clock (clock),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (mis),
      .wdata ({pred_taken, pred_fallthru}),
      .rdata (head),
      .count (count)
   );
   always_comb begin
      state_d    = mis ? FLUSH : RUN;
      redirect_d = pop ? (res_taken ? res_target : head.fallthru) : redirect_q;
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= RUN;
         upd_valid_q  <= 1'b0;
         upd_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         upd_valid_q  <= pop;
         upd_taken_q  <= pop && res_taken;
         mispredict_q <= mis;
         redirect_q   <= redirect_d;
         underflow_q  <= underflow_q || (res_valid && empty);
      end
   end
   assign upd_valid     = upd_valid_q;
   assign upd_taken     = upd_taken_q;
   assign mispredict    = mispredict_q;
   assign redirect_pc   = redirect_q;
   assign underflow_err = underflow_q;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [CNT_W-1:0] br_q, mp_q;
   always_ff @(posedge clock) begin
      if (rst) begin
         br_q <= '0;
         mp_q <= '0;
      end else begin
         if (pop && !(&br_q)) br_q <= br_q + CNT_W'(1);
         if (mis && !(&mp_q)) mp_q <= mp_q + CNT_W'(1);
      end
   end
   assign stat_branches = br_q;
   assign stat_mispred  = mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit (stats checks under BRANCH_RESOLVE_STATS_EN).
module tb_branch_resolve_unit;
   logic        clock = 1'b0, rst = 1'b1;
   logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
   logic [31:0] pred_fallthru = '0, res_target = '0;
   logic        pred_ready, upd_valid, upd_taken, mispredict, empty, underflow_err;
   logic [31:0] redirect_pc;
   int          checks = 0, failures = 0;
   typedef struct {
      logic        taken;
      logic        mis;
      logic [31:0] pc;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [15:0] stat_branches, stat_mispred;
   logic        s_ready, s_uv, s_ut, s_mis, s_empty, s_uf;
   logic [31:0] s_pc;
   logic [1:0]  s_br, s_mp;
`endif

   branch_resolve_unit dut (
      .clock(clock), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_fallthru(pred_fallthru),
      .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .empty(empty), .underflow_err(underflow_err)
`ifdef BRANCH_RESOLVE_STATS_EN
      , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
   );

`ifdef BRANCH_RESOLVE_STATS_EN
   branch_resolve_unit #(.CNT_W(2)) u_sat (
      .clock(clock), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_fallthru(pred_fallthru),
      .pred_ready(s_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .upd_valid(s_uv), .upd_taken(s_ut), .mispredict(s_mis),
      .redirect_pc(s_pc), .empty(s_empty), .underflow_err(s_uf),
      .stat_branches(s_br), .stat_mispred(s_mp)
   );
`endif

   always @(negedge clock) begin
      exp_t e;
      if (upd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_upd got taken=%0b mis=%0b pc=%h, required no update", upd_taken, mispredict, redirect_pc);
         end else begin
            e = exp_q.pop_front();
            if ({upd_taken, mispredict, redirect_pc} !== {e.taken, e.mis, e.pc}) begin
               failures++;
               $display("FAIL upd got taken=%0b mis=%0b pc=%h, required taken=%0b mis=%0b pc=%h",
                        upd_taken, mispredict, redirect_pc, e.taken, e.mis, e.pc);
            end
         end
      end else if (mispredict) begin
         checks++;
         failures++;
         $display("FAIL stray_mispredict got 1 without upd_valid, required 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got %h, required %h", n, a, e);
      end
   endtask

   task automatic cyc(input logic pv, input logic pt, input logic [31:0] pf,
                      input logic rv, input logic rt, input logic [31:0] rtg);
      pred_valid = pv; pred_taken = pt; pred_fallthru = pf;
      res_valid = rv; res_taken = rt; res_target = rtg;
      @(posedge clock);
      #1;
      pred_valid = 0; pred_taken = 0; pred_fallthru = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
   endtask

   task automatic rsv(input logic rt, input logic [31:0] tgt, input logic emis, input logic [31:0] epc);
      exp_q.push_back('{rt, emis, epc});
      cyc(0, 0, 0, 1, rt, tgt);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1 rst = 0;
      @(negedge clock);
      chk("reset_empty", 32'(empty), 1);
      chk("reset_ready", 32'(pred_ready), 1);
      chk("reset_upd_valid", 32'(upd_valid), 0);
      chk("reset_mispredict", 32'(mispredict), 0);
      chk("reset_redirect", redirect_pc, 0);
      chk("reset_underflow", 32'(underflow_err), 0);
      // correct predictions in order
      cyc(1, 1, 32'h10, 0, 0, 0);
      cyc(1, 0, 32'h20, 0, 0, 0);
      cyc(1, 1, 32'h30, 0, 0, 0);
      rsv(1, 32'hA0, 0, 32'hA0);
      rsv(0, 32'hB0, 0, 32'h20);
      rsv(1, 32'hC0, 0, 32'hC0);
      @(negedge clock);
      chk("t1_empty", 32'(empty), 1);
      // predicted not-taken, actually taken
      cyc(1, 0, 32'h104, 0, 0, 0);
      rsv(1, 32'h200, 1, 32'h200);
      @(negedge clock);
      chk("t2_flush_ready", 32'(pred_ready), 0);
      @(negedge clock);
      chk("t2_run_ready", 32'(pred_ready), 1);
      // predicted taken, actually not taken; younger and same-cycle pushes are dropped
      cyc(1, 1, 32'h44, 0, 0, 0);
      cyc(1, 0, 32'h48, 0, 0, 0);
      cyc(1, 1, 32'h4C, 0, 0, 0);
      exp_q.push_back('{1'b0, 1'b1, 32'h44});
      cyc(1, 0, 32'h50, 1, 0, 32'h999);
      @(negedge clock);
      chk("t3_flush_empty", 32'(empty), 1);
      chk("t3_flush_ready", 32'(pred_ready), 0);
      repeat (3) @(negedge clock);
      chk("t3_still_empty", 32'(empty), 1);
      // fill, then push+pop on a full queue
      for (int i = 0; i < 4; i++) cyc(1, 0, 32'h100 + 32'(4 * i), 0, 0, 0);
      @(negedge clock);
      chk("t4_full_ready", 32'(pred_ready), 0);
      exp_q.push_back('{1'b0, 1'b0, 32'h100});
      cyc(1, 0, 32'h1F0, 1, 0, 0);
      @(negedge clock);
      chk("t4_push_refused_ready", 32'(pred_ready), 1);
      chk("t4_not_empty", 32'(empty), 0);
      rsv(0, 0, 0, 32'h104);
      rsv(0, 0, 0, 32'h108);
      rsv(0, 0, 0, 32'h10C);
      @(negedge clock);
      chk("t4_drained", 32'(empty), 1);
      // wrap-around with simultaneous push/pop
      cyc(1, 0, 32'h300, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back('{1'b0, 1'b0, 32'h300 + 32'(4 * i)});
         cyc(1, 0, 32'h304 + 32'(4 * i), 1, 0, 0);
      end
      rsv(0, 0, 0, 32'h328);
      @(negedge clock);
      chk("t4_wrap_empty", 32'(empty), 1);
      // underflow and mid-operation reset
      chk("t5_no_underflow", 32'(underflow_err), 0);
      cyc(0, 0, 0, 1, 1, 32'h77);
      @(negedge clock);
      chk("t5_underflow", 32'(underflow_err), 1);
      chk("t5_no_upd", 32'(upd_valid), 0);
      repeat (3) @(negedge clock);
      chk("t5_underflow_sticky", 32'(underflow_err), 1);
      cyc(1, 1, 32'h600, 0, 0, 0);
      cyc(1, 0, 32'h604, 0, 0, 0);
      rst = 1;
      @(posedge clock);
      #1 rst = 0;
      @(negedge clock);
      chk("t5_rst_empty", 32'(empty), 1);
      chk("t5_rst_underflow", 32'(underflow_err), 0);
      chk("t5_rst_upd_valid", 32'(upd_valid), 0);
      chk("t5_rst_mispredict", 32'(mispredict), 0);
      chk("t5_rst_redirect", redirect_pc, 0);
      chk("t5_rst_ready", 32'(pred_ready), 1);
      repeat (3) @(negedge clock);
`ifdef BRANCH_RESOLVE_STATS_EN
      for (int i = 0; i < 5; i++) begin
         logic rt;
         rt = !(i == 1 || i == 3);
         cyc(1, 1, 32'h700 + 32'(4 * i), 0, 0, 0);
         rsv(rt, 32'h800 + 32'(4 * i), !rt, rt ? 32'h800 + 32'(4 * i) : 32'h700 + 32'(4 * i));
         cyc(0, 0, 0, 0, 0, 0);
      end
      @(negedge clock);
      chk("stat_branches", 32'(stat_branches), 5);
      chk("stat_mispred", 32'(stat_mispred), 2);
      chk("stat_branches_sat", 32'(s_br), 3);
      chk("stat_mispred_w2", 32'(s_mp), 2);
`endif
      repeat (2) @(negedge clock);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
